npc_deadtime_multi: RTL and testbench

Parametrised successor of the single-leg NPC dead-time block. It drives N_LEGS three-level NPC legs with four switch gates each, and inserts a programmable dead time on every transition. Direct +/- reversals are forced through a minimum zero-state dwell, and an ordered outer-then-inner fault shutdown is provided. The block sits between the modulator/MPC leg-state outputs and the gate-driver pins.

---
 rtl/npc_deadtime_multi.sv | 188 ++++++++++++++++++
 tb/tb_npc_deadtime_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/npc_deadtime_multi.sv
// rtl/npc_deadtime_multi.sv - N-leg three-level NPC gate sequencer with dead time,
// zero-state dwell on reversals and ordered outer-then-inner fault shutdown.
module npc_deadtime_multi #(
  parameter int N_LEGS = 3,
  parameter int DT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [2*N_LEGS-1:0]   leg,
  input  logic [DT_W-1:0]       dead_cycles,
  input  logic                  fault,
  input  logic                  err_clr,
  output logic [4*N_LEGS-1:0]   out,
  output logic [N_LEGS-1:0]     busy,
  output logic [N_LEGS-1:0]     err
);

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_DT  = 3'd1,
    ST_P   = 3'd2,
    ST_Z   = 3'd3,
    ST_N   = 3'd4,
    ST_SD  = 3'd5
  } state_e;

  // Command / target encoding shared with the leg input: 0 = N, 2 = Z, 3 = P.
  localparam logic [1:0] CMD_N   = 2'd0;
  localparam logic [1:0] CMD_BAD = 2'd1;
  localparam logic [1:0] CMD_Z   = 2'd2;
  localparam logic [1:0] CMD_P   = 2'd3;

  localparam logic [3:0] PAT_P    = 4'b1100;
  localparam logic [3:0] PAT_Z    = 4'b0110;
  localparam logic [3:0] PAT_N    = 4'b0011;
  localparam logic [3:0] PAT_P2Z  = 4'b0100;
  localparam logic [3:0] PAT_N2Z  = 4'b0010;
  localparam logic [3:0] INNER    = 4'b0110;

  localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

  logic [DT_W-1:0] d_load;
  assign d_load = (dead_cycles == '0) ? CNT_ONE : dead_cycles;

  function automatic logic [3:0] tgt_pattern(input logic [1:0] t);
    case (t)
      CMD_P:   tgt_pattern = PAT_P;
      CMD_N:   tgt_pattern = PAT_N;
      default: tgt_pattern = PAT_Z;
    endcase
  endfunction

  function automatic state_e tgt_state(input logic [1:0] t);
    case (t)
      CMD_P:   tgt_state = ST_P;
      CMD_N:   tgt_state = ST_N;
      default: tgt_state = ST_Z;
    endcase
  endfunction

  for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
    state_e          st_q;
    logic [DT_W-1:0] cnt_q;
    logic [1:0]      tgt_q;
    logic [3:0]      out_q;
    logic            busy_q;
    logic            err_q;
    logic [1:0]      cmd;

    assign cmd = leg[2*i +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= ST_OFF;
        cnt_q  <= '0;
        tgt_q  <= CMD_Z;
        out_q  <= '0;
        busy_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        // A new invalid command wins over a simultaneous clear.
        if (ce && cmd == CMD_BAD) begin
          err_q <= 1'b1;
        end else if (err_clr) begin
          err_q <= 1'b0;
        end

        // Fault bypasses ce: outer switches drop first, inner ones after the SD count.
        if (fault && st_q inside {ST_DT, ST_P, ST_Z, ST_N}) begin
          out_q  <= out_q & INNER;
          cnt_q  <= d_load;
          st_q   <= ST_SD;
          busy_q <= 1'b1;
        end else if (!ce) begin
          if (st_q == ST_OFF) busy_q <= 1'b1;
        end else begin
          case (st_q)
            ST_OFF: begin
              busy_q <= 1'b1;
              if (!fault) begin
                cnt_q <= d_load;
                tgt_q <= CMD_Z;
                st_q  <= ST_DT;
              end
            end

            ST_DT: begin
              if (cnt_q <= CNT_ONE) begin
                out_q  <= tgt_pattern(tgt_q);
                st_q   <= tgt_state(tgt_q);
                cnt_q  <= (tgt_q == CMD_Z) ? d_load : '0;
                busy_q <= (tgt_q == CMD_Z);
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end

            ST_P: begin
              if (cmd == CMD_Z || cmd == CMD_N) begin
                out_q  <= PAT_P2Z;
                tgt_q  <= CMD_Z;
                cnt_q  <= d_load;
                st_q   <= ST_DT;
                busy_q <= 1'b1;
              end
            end

            ST_N: begin
              if (cmd == CMD_Z || cmd == CMD_P) begin
                out_q  <= PAT_N2Z;
                tgt_q  <= CMD_Z;
                cnt_q  <= d_load;
                st_q   <= ST_DT;
                busy_q <= 1'b1;
              end
            end

            // The dwell's last cycle is cnt = 1, so Z holds for exactly D ce-cycles.
            ST_Z: begin
              if (cnt_q > CNT_ONE) begin
                cnt_q <= cnt_q - CNT_ONE;
              end else if (cmd == CMD_P) begin
                out_q  <= PAT_P2Z;
                tgt_q  <= CMD_P;
                cnt_q  <= d_load;
                st_q   <= ST_DT;
                busy_q <= 1'b1;
              end else if (cmd == CMD_N) begin
                out_q  <= PAT_N2Z;
                tgt_q  <= CMD_N;
                cnt_q  <= d_load;
                st_q   <= ST_DT;
                busy_q <= 1'b1;
              end else begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
              end
            end

            ST_SD: begin
              if (cnt_q <= CNT_ONE) begin
                out_q  <= '0;
                cnt_q  <= '0;
                st_q   <= ST_OFF;
                busy_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end

            default: begin
              out_q  <= '0;
              cnt_q  <= '0;
              st_q   <= ST_OFF;
              busy_q <= 1'b1;
            end
          endcase
        end
      end
    end

    assign out[4*i +: 4] = out_q;
    assign busy[i]       = busy_q;
    assign err[i]        = err_q;
  end

endmodule

// File: tb/tb_npc_deadtime_multi.sv
// tb/tb_npc_deadtime_multi.sv - scoreboard bench for npc_deadtime_multi (3 legs).
module tb_npc_deadtime_multi;

  localparam int NL = 3;
  localparam int DW = 8;

  localparam logic [3:0] G_P   = 4'b1100;
  localparam logic [3:0] G_Z   = 4'b0110;
  localparam logic [3:0] G_N   = 4'b0011;
  localparam logic [3:0] G_P2Z = 4'b0100;
  localparam logic [3:0] G_N2Z = 4'b0010;
  localparam logic [3:0] G_OFF = 4'b0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ce;
  logic [2*NL-1:0] leg;
  logic [DW-1:0]   dead_cycles;
  logic            fault;
  logic            err_clr;
  logic [4*NL-1:0] out;
  logic [NL-1:0]   busy;
  logic [NL-1:0]   err;

  always #5 clk = ~clk;

  npc_deadtime_multi #(.N_LEGS(NL), .DT_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .leg         (leg),
    .dead_cycles (dead_cycles),
    .fault       (fault),
    .err_clr     (err_clr),
    .out         (out),
    .busy        (busy),
    .err         (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] o;
    logic [2:0]  b;
    logic [2:0]  e;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  eo0, eo1, eo2;
  logic [2:0]  eb, ee;
  string       phase;

  task automatic set_leg(input int i, input logic [1:0] c);
    leg[2*i +: 2] = c;
  endtask

  // Expectations describe the state right after the next rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t x;
      @(posedge clk);
      x.o   = {eo2, eo1, eo0};
      x.b   = eb;
      x.e   = ee;
      x.tag = phase;
      sb.push_back(x);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    logic shoot;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq({x.tag, ":out"},  32'(out),  32'(x.o));
      check_eq({x.tag, ":busy"}, 32'(busy), 32'(x.b));
      check_eq({x.tag, ":err"},  32'(err),  32'(x.e));
      shoot = 1'b0;
      for (int l = 0; l < NL; l++) begin
        if ((out[4*l+3] && out[4*l+1]) || (out[4*l+2] && out[4*l])) shoot = 1'b1;
      end
      check_eq({x.tag, ":shoot"}, 32'(shoot), 32'd0);
    end
  end

  initial begin
    rst_n       = 1'b0;
    ce          = 1'b1;
    fault       = 1'b0;
    err_clr     = 1'b0;
    dead_cycles = 8'd3;
    leg         = 6'b10_10_10;
    eo0 = G_OFF; eo1 = G_OFF; eo2 = G_OFF; eb = 3'b000; ee = 3'b000;
    phase = "reset";

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset:out",  32'(out),  32'd0);
    check_eq("reset:busy", 32'(busy), 32'd0);
    check_eq("reset:err",  32'(err),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    phase = "startup";
    eb = 3'b111;
    step(3);
    eo0 = G_Z; eo1 = G_Z; eo2 = G_Z;
    step(3);
    eb = 3'b000;
    step(2);

    phase = "z_to_p";
    set_leg(0, 2'd3);
    eo0 = G_P2Z; eb = 3'b001;
    step(3);
    eo0 = G_P; eb = 3'b000;
    step(2);

    phase = "p_to_n";
    set_leg(0, 2'd0);
    eo0 = G_P2Z; eb = 3'b001;
    step(3);
    eo0 = G_Z;
    step(3);
    eo0 = G_N2Z;
    step(3);
    eo0 = G_N; eb = 3'b000;
    step(2);

    phase = "n_to_z";
    set_leg(0, 2'd2);
    eo0 = G_N2Z; eb = 3'b001;
    step(3);
    eo0 = G_Z;
    step(3);
    eb = 3'b000;
    step(1);

    phase = "invalid";
    set_leg(1, 2'd1);
    ee = 3'b010;
    step(1);
    set_leg(1, 2'd2);
    step(2);
    err_clr = 1'b1;
    ee = 3'b000;
    step(1);
    err_clr = 1'b0;
    step(1);

    phase = "err_race";
    set_leg(2, 2'd1);
    err_clr = 1'b1;
    ee = 3'b100;
    step(1);
    set_leg(2, 2'd2);
    ee = 3'b000;
    step(1);
    err_clr = 1'b0;
    step(1);

    phase = "fault";
    set_leg(0, 2'd3);
    eo0 = G_P2Z; eb = 3'b001;
    step(3);
    eo0 = G_P; eb = 3'b000;
    step(1);
    fault = 1'b1;
    eo0 = G_P2Z; eo1 = G_Z; eo2 = G_Z; eb = 3'b111;
    step(3);
    eo0 = G_OFF; eo1 = G_OFF; eo2 = G_OFF;
    step(2);
    phase = "restart";
    fault = 1'b0;
    set_leg(0, 2'd2);
    step(3);
    eo0 = G_Z; eo1 = G_Z; eo2 = G_Z;
    step(3);
    eb = 3'b000;
    step(1);

    phase = "ce_toggle";
    set_leg(0, 2'd3);
    eo0 = G_P2Z; eb = 3'b001;
    for (int k = 0; k < 6; k++) begin
      ce = (k % 2 == 0);
      step(1);
    end
    ce = 1'b1;
    eo0 = G_P; eb = 3'b000;
    step(1);

    phase = "dt_zero";
    dead_cycles = 8'd0;
    set_leg(0, 2'd2);
    eo0 = G_P2Z; eb = 3'b001;
    step(1);
    eo0 = G_Z;
    step(1);
    eb = 3'b000;
    step(1);
    set_leg(0, 2'd3);
    eo0 = G_P2Z; eb = 3'b001;
    step(1);
    eo0 = G_P; eb = 3'b000;
    step(1);

    phase = "dt_change";
    dead_cycles = 8'd3;
    set_leg(0, 2'd2);
    eo0 = G_P2Z; eb = 3'b001;
    step(1);
    dead_cycles = 8'd5;
    step(2);
    eo0 = G_Z;
    step(5);
    eb = 3'b000;
    step(1);

    @(negedge clk);
    #1;
    check_eq("drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
